// File: rtl/product_accumulator_if.sv
// Product-beat input and accumulated-result output handshakes of product_accumulator.
interface product_accumulator_if #(
  parameter int N     = 4,
  parameter int ACC_W = 16,
  parameter int CNT_W = 8
);
  logic signed [2*N-1:0]   prod_i;
  logic                    prod_valid;
  logic                    prod_last;
  logic                    prod_ready;
  logic signed [ACC_W-1:0] acc_o;
  logic [CNT_W-1:0]        cnt_o;
  logic                    ovf_o;
  logic                    acc_valid;
  logic                    acc_ready;

  modport master (
    output prod_i, prod_valid, prod_last, acc_ready,
    input  prod_ready, acc_o, cnt_o, ovf_o, acc_valid
  );

  modport slave (
    input  prod_i, prod_valid, prod_last, acc_ready,
    output prod_ready, acc_o, cnt_o, ovf_o, acc_valid
  );
endinterface

// File: rtl/product_accumulator.sv
// Saturating signed accumulator over a packet of multiplier products, with beat count and sticky overflow.
// Latency: result valid the cycle after the last beat is accepted.
// Backpressure: holds the result (prod_ready=0) until acc_ready; one bubble cycle between packets.
module product_accumulator #(
  parameter int N     = 4,
  parameter int ACC_W = 16,
  parameter int CNT_W = 8
) (
  input  logic                 clk,
  input  logic                 rst,
  product_accumulator_if.slave bus
);

  typedef enum logic {ACCUM = 1'b0, HOLD = 1'b1} state_t;

  localparam logic signed [ACC_W-1:0] ACC_MAX = {1'b0, {(ACC_W-1){1'b1}}};
  localparam logic signed [ACC_W-1:0] ACC_MIN = {1'b1, {(ACC_W-1){1'b0}}};
  localparam logic [CNT_W-1:0]        CNT_MAX = {CNT_W{1'b1}};

  state_t                  state;
  logic signed [ACC_W-1:0] acc;
  logic [CNT_W-1:0]        cnt;
  logic                    ovf;

  logic signed [ACC_W:0]   sum;
  logic signed [ACC_W-1:0] sum_sat;
  logic                    sat_hit;
  logic                    accept;

  assign accept = (state == ACCUM) && bus.prod_valid;

  // One guard bit: the top two bits disagree exactly when the true sum left the ACC_W range.
  always_comb begin
    sum     = '0;
    sum_sat = '0;
    sat_hit = 1'b0;
    sum     = {acc[ACC_W-1], acc}
            + {{(ACC_W+1-2*N){bus.prod_i[2*N-1]}}, bus.prod_i};
    sat_hit = sum[ACC_W] != sum[ACC_W-1];
    if (!sat_hit)
      sum_sat = sum[ACC_W-1:0];
    else if (sum[ACC_W])
      sum_sat = ACC_MIN;
    else
      sum_sat = ACC_MAX;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= ACCUM;
      acc   <= '0;
      cnt   <= '0;
      ovf   <= 1'b0;
    end else begin
      case (state)
        ACCUM: begin
          if (accept) begin
            acc <= sum_sat;
            cnt <= (cnt == CNT_MAX) ? cnt : cnt + CNT_W'(1);
            ovf <= ovf | sat_hit;
            if (bus.prod_last)
              state <= HOLD;
          end
        end
        HOLD: begin
          if (bus.acc_ready) begin
            state <= ACCUM;
            acc   <= '0;
            cnt   <= '0;
            ovf   <= 1'b0;
          end
        end
        default: state <= ACCUM;
      endcase
    end
  end

  assign bus.prod_ready = (state == ACCUM);
  assign bus.acc_valid  = (state == HOLD);
  assign bus.acc_o      = acc;
  assign bus.cnt_o      = cnt;
  assign bus.ovf_o      = ovf;

endmodule

// File: doc/product_accumulator.md
PRODUCT_ACCUMULATOR -- requirements
Module: product_accumulator

Interface
REQ-001 SHALL have parameter N, default 4: multiplier operand width; the product is 2N bits.
REQ-002 SHALL have parameter ACC_W, default 16: accumulator width, ACC_W >= 2N.
REQ-003 SHALL have parameter CNT_W, default 8: beat counter width.
REQ-004 SHALL have port clk  input  1  clock; all state updates on the rising edge.
REQ-005 SHALL have port rst  input  1  reset, asynchronous, active-high (one clock; reset is asynchronous and active-high).
REQ-006 SHALL have port prod_i  input  2N  signed product from the upstream multiplier.
REQ-007 SHALL have port prod_valid  input  1  prod_i is valid this cycle.
REQ-008 SHALL have port prod_last  input  1  current beat is the last product of the packet.
REQ-009 SHALL have port prod_ready  output  1  block accepts a product this cycle.
REQ-010 SHALL have port acc_o  output  ACC_W  signed accumulated sum.
REQ-011 SHALL have port cnt_o  output  CNT_W  number of products accumulated in the packet.
REQ-012 SHALL have port ovf_o  output  1  sticky saturation flag for the packet.
REQ-013 SHALL have port acc_valid  output  1  acc_o, cnt_o and ovf_o hold a completed result.
REQ-014 SHALL have port acc_ready  input  1  downstream consumes the result.

Function
REQ-015 SHALL implement two states: ACCUM and HOLD.
REQ-016 SHALL drive prod_ready=1 in ACCUM and 0 in HOLD, decoded from state only.
REQ-017 SHALL drive acc_valid=1 in HOLD and 0 in ACCUM, decoded from state only.
REQ-018 SHALL treat a beat as accepted only when prod_valid and prod_ready are both 1; prod_i and prod_last SHALL be ignored otherwise.
REQ-019 On an accepted beat, SHALL compute acc + sext(prod_i) at ACC_W+1 bits and store it saturated to the signed ACC_W range.
REQ-020 SHALL set ovf_o on any saturating beat; ovf_o SHALL stay set until the packet ends.
REQ-021 SHALL increment cnt_o on each accepted beat, saturating at 2^CNT_W-1 with no wrap.
REQ-022 SHALL move ACCUM->HOLD on an accepted beat with prod_last=1; that beat is included in the result.
REQ-023 Latency: acc_valid SHALL rise on the clock edge that accepts the last beat, so the result is visible in the following cycle.
REQ-024 In HOLD, acc_o, cnt_o and ovf_o SHALL be stable.
REQ-025 In HOLD, SHALL move HOLD->ACCUM when acc_ready=1 and SHALL clear acc to 0, cnt to 0 and ovf to 0 on that edge.
REQ-026 SHALL insert one bubble between packets: no product is accepted in the cycle the result is consumed.
REQ-027 A single-beat packet (prod_last on the first beat) SHALL yield acc_o = sext(prod_i) and cnt_o = 1.
REQ-028 acc_o SHALL reflect the running sum in ACCUM; that value is informational only while acc_valid=0.
REQ-029 SHALL accept back-to-back beats at one beat per cycle in ACCUM.

Reset
REQ-030 On rst=1, asynchronously: state=ACCUM, acc_o=0, cnt_o=0, ovf_o=0, acc_valid=0, prod_ready=1.
REQ-031 rst asserted mid-packet or in HOLD SHALL discard the partial or held result; no acc_valid pulse SHALL follow.
REQ-032 After rst deasserts, the first accepted beat SHALL start a new packet from acc=0.

Verification (N=4)
REQ-033 Reset check: assert rst -> acc_o=0, cnt_o=0, ovf_o=0, acc_valid=0, prod_ready=1, with no clock edge required.
REQ-034 Basic packet, ACC_W=16: beats 3, -5, 7(last) on consecutive cycles -> next cycle acc_o=5, cnt_o=3, ovf_o=0, acc_valid=1.
REQ-035 Saturation, ACC_W=10: nine beats of 64 -> acc_o=511, ovf_o=1; ten beats of -56 -> acc_o=-512, ovf_o=1.
REQ-036 Backpressure: acc_ready=0 for 5 cycles in HOLD with prod_valid=1 -> outputs stable, prod_ready=0, no beat accepted; then acc_ready=1 -> next cycle acc_valid=0, prod_ready=1, cnt_o=0.
REQ-037 Single-beat packet: beat -8 with prod_last=1 -> acc_o=-8, cnt_o=1, acc_valid=1 next cycle.
REQ-038 Reset mid-packet: beats 10, 20, then a rst pulse, then beat 2(last) -> acc_o=2, cnt_o=1, ovf_o=0.
